// File: rtl/instr_sequencer_rv_pkg.sv
// Shared control constants for the RV32I multi-cycle sequencer: FSM state
// encodings, reset NOP, next-PC selector and register write-source codes.
package instr_sequencer_rv_pkg;

    localparam logic [2:0] ST_FETCH     = 3'd0;
    localparam logic [2:0] ST_DECODE    = 3'd1;
    localparam logic [2:0] ST_EXECUTE   = 3'd2;
    localparam logic [2:0] ST_MEM       = 3'd3;
    localparam logic [2:0] ST_WRITEBACK = 3'd4;
    localparam logic [2:0] ST_TRAP      = 3'd5;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [1:0] NEXT_PC_SRC_SEQ  = 2'd0;
    localparam logic [1:0] NEXT_PC_SRC_JAL  = 2'd1;
    localparam logic [1:0] NEXT_PC_SRC_JALR = 2'd2;
    localparam logic [1:0] NEXT_PC_SRC_B    = 2'd3;

    localparam logic [1:0] REG_SOURCE_ALU    = 2'd0;
    localparam logic [1:0] REG_SOURCE_MEMORY = 2'd1;
    localparam logic [1:0] REG_SOURCE_PC4    = 2'd2;
    localparam logic [1:0] REG_SOURCE_IMM    = 2'd3;

endpackage

// File: rtl/instr_sequencer_rv_next_pc.sv
// next_pc_rv: combinational next-PC target select with immediate
// unscrambling, sign extension and a misaligned-target flag.
module next_pc_rv
    import instr_sequencer_rv_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [1:0]  nextPcSrc,
    input  logic [19:0] imm20,
    input  logic [11:0] imm12,
    input  logic [31:0] rs1Data,
    input  logic        branchInverted,
    input  logic        aluResult0,
    output logic [31:0] target,
    output logic        misaligned
);

    logic [31:0] seqPc;
    logic [31:0] jalOffset;
    logic [31:0] branchOffset;
    logic [31:0] jalrSum;

    // J and B immediates arrive in raw instruction bit order; reassemble them here.
    assign seqPc        = pc + 32'd4;
    assign jalOffset    = {{11{imm20[19]}}, imm20[19], imm20[7:0], imm20[8], imm20[18:9], 1'b0};
    assign branchOffset = {{19{imm12[11]}}, imm12[11], imm12[0], imm12[10:5], imm12[4:1], 1'b0};
    assign jalrSum      = rs1Data + {{20{imm12[11]}}, imm12};

    always_comb begin
        target = seqPc;
        case (nextPcSrc)
            NEXT_PC_SRC_JAL:  target = pc + jalOffset;
            NEXT_PC_SRC_JALR: target = jalrSum & 32'hFFFF_FFFE;
            NEXT_PC_SRC_B:    target = (aluResult0 ^ branchInverted) ? pc + branchOffset : seqPc;
            default:          target = seqPc;
        endcase
    end

    assign misaligned = |target[1:0];

endmodule

// File: rtl/instr_sequencer_rv.sv
// Multi-cycle RV32I control sequencer: PC, IR, retire counter and memory handshakes.
// Define INSTR_SEQUENCER_TRAP_EN to make illegal/misaligned instructions lock into TRAP.
//   state     | meaning
//   FETCH     | instruction request outstanding until ack
//   DECODE    | decoder / register-file settle cycle
//   EXECUTE   | latch next PC, choose MEM, WRITEBACK or illegal path
//   MEM       | data request outstanding until ack
//   WRITEBACK | write strobe, PC update, retire
//   TRAP      | sticky halt, left only by reset
module instr_sequencer_rv
    import instr_sequencer_rv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        iwClk,
    input  logic        iwRst,
    output logic        owIMemReq,
    output logic [31:0] owIMemAddr,
    input  logic        iwIMemAck,
    input  logic [31:0] iwIMemData,
    output logic [31:0] owInstr,
    output logic [31:0] owPc,
    input  logic        iwnIllegal,
    input  logic [1:0]  iwNextPcSrc,
    input  logic [19:0] iwNextPcImmediate20,
    input  logic [11:0] iwNextPcImmediate12,
    input  logic [31:0] iwRs1Data,
    input  logic        iwBranchInverted,
    input  logic        iwAluResult0,
    input  logic [1:0]  iwWriteRegSource,
    input  logic        iwDMemWrite,
    output logic        owDMemReq,
    input  logic        iwDMemAck,
    output logic        owRegWriteEn,
    output logic [31:0] owRetired,
    output logic        owTrap
);

    logic [2:0]  state;
    logic [31:0] nextPcReg;
    logic [31:0] target;
    logic        misaligned;
    logic        isLoad;
    logic        isBranch;
    logic        illegalPath;

    assign isLoad      = (iwWriteRegSource == REG_SOURCE_MEMORY);
    assign isBranch    = (iwNextPcSrc == NEXT_PC_SRC_B);
    assign illegalPath = !iwnIllegal || misaligned;
    assign owIMemAddr  = owPc;

`ifndef INSTR_SEQUENCER_TRAP_EN
    assign owTrap = 1'b0;
`endif

    next_pc_rv uNextPc (
        .pc             (owPc),
        .nextPcSrc      (iwNextPcSrc),
        .imm20          (iwNextPcImmediate20),
        .imm12          (iwNextPcImmediate12),
        .rs1Data        (iwRs1Data),
        .branchInverted (iwBranchInverted),
        .aluResult0     (iwAluResult0),
        .target         (target),
        .misaligned     (misaligned)
    );

    always_ff @(posedge iwClk or posedge iwRst) begin
        if (iwRst) begin
            state        <= ST_FETCH;
            owPc         <= RESET_PC;
            nextPcReg    <= RESET_PC;
            owInstr      <= NOP_INSTR;
            owIMemReq    <= 1'b0;
            owDMemReq    <= 1'b0;
            owRegWriteEn <= 1'b0;
            owRetired    <= 32'd0;
`ifdef INSTR_SEQUENCER_TRAP_EN
            owTrap       <= 1'b0;
`endif
        end else begin
            owRegWriteEn <= 1'b0;
            case (state)
                ST_FETCH: begin
                    // Request is low for the first FETCH cycle after reset; acks then are ignored.
                    if (owIMemReq && iwIMemAck) begin
                        owInstr   <= iwIMemData;
                        owIMemReq <= 1'b0;
                        state     <= ST_DECODE;
                    end else begin
                        owIMemReq <= 1'b1;
                    end
                end
                ST_DECODE: state <= ST_EXECUTE;
                ST_EXECUTE: begin
                    nextPcReg <= target;
                    if (illegalPath) begin
`ifdef INSTR_SEQUENCER_TRAP_EN
                        owTrap <= 1'b1;
                        state  <= ST_TRAP;
`else
                        nextPcReg <= owPc + 32'd4;
                        state     <= ST_WRITEBACK;
`endif
                    end else if (isLoad || iwDMemWrite) begin
                        owDMemReq <= 1'b1;
                        state     <= ST_MEM;
                    end else begin
                        owRegWriteEn <= !isBranch;
                        state        <= ST_WRITEBACK;
                    end
                end
                ST_MEM: begin
                    if (owDMemReq && iwDMemAck) begin
                        owDMemReq    <= 1'b0;
                        owRegWriteEn <= !iwDMemWrite;
                        state        <= ST_WRITEBACK;
                    end
                end
                ST_WRITEBACK: begin
                    owPc      <= nextPcReg;
                    owRetired <= owRetired + 32'd1;
                    owIMemReq <= 1'b1;
                    state     <= ST_FETCH;
                end
`ifdef INSTR_SEQUENCER_TRAP_EN
                ST_TRAP: state <= ST_TRAP;
`endif
                default: state <= ST_FETCH;
            endcase
        end
    end

endmodule
